// File: rtl/memory_stage_if.sv
// EX/MEM to MEM/WB bus of the memory stage.
// The master drives the EX/MEM register and the slave (the stage) returns the
// MEM/WB register, the hazard stall and the misaligned-access flag.
interface memory_stage_if;
    logic [74:0] EXMEMReg;
    logic [70:0] MEMWBReg;
    logic        memStall;
    logic        addrError;

    modport master (
        output EXMEMReg,
        input  MEMWBReg,
        input  memStall,
        input  addrError
    );

    modport slave (
        input  EXMEMReg,
        output MEMWBReg,
        output memStall,
        output addrError
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline MEM stage: data-memory load/store with configurable access latency.
//
//   state | meaning
//   IDLE  | accepting a new op; single-cycle ops and squashed ops complete here
//   BUSY  | multi-cycle access in flight, counter holds the remaining cycles
//
// The upstream stages must hold EXMEMReg stable while memStall is high,
// because the request fields are only sampled on the completing edge.
module memory_stage #(
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    memory_stage_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam bit MULTI = (MEM_LATENCY > 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] counter;
    logic [70:0]      memwb_q;
    logic             addr_err_q;
    logic [31:0]      mem [DEPTH];

    logic              reg_write, mem_write, mem_to_reg, mem_read, overflow, zero;
    logic [4:0]        write_reg;
    logic [31:0]       store_data, alu_result;
    logic [ADDR_W-1:0] mem_idx;
    logic              req, misaligned, valid_req, is_load, busy;
    logic              reg_write_eff, stall, complete, mem_we;
    logic [31:0]       rd_data;
    logic              unused_bits;

    assign {reg_write, mem_write, mem_to_reg, mem_read, overflow, zero,
            write_reg, store_data, alu_result} = bus.EXMEMReg;

    // zero is not forwarded and upper address bits only wrap the index
    assign unused_bits = ^{zero, alu_result[31:ADDR_W+2]};

    assign mem_idx       = alu_result[ADDR_W+1:2];
    assign req           = mem_read | mem_write;
    assign misaligned    = req & (alu_result[1:0] != 2'b00);
    assign valid_req     = req & ~misaligned & ~overflow;
    // a combined read+write request is treated as a store
    assign is_load       = mem_read & ~mem_write;
    assign reg_write_eff = reg_write & ~overflow & ~misaligned;
    assign busy          = (state == S_BUSY);
    assign rd_data       = mem[mem_idx];

    // Stall / completion decode for the current cycle.
    always_comb begin
        stall    = 1'b0;
        complete = 1'b0;
        if (valid_req) begin
            if (!busy) begin
                stall    = MULTI;
                complete = !MULTI;
            end else begin
                stall    = (counter > CNT_W'(1));
                complete = (counter == CNT_W'(1));
            end
        end
    end

    // Only the completing edge of a valid store touches the array; a store
    // interrupted by reset never gets here.
    assign mem_we = rst_n & complete & mem_write;

    // Data memory array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= store_data;
        end
    end

    // FSM, latency counter and MEM/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            counter    <= '0;
            memwb_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= misaligned & ~busy;
            if (valid_req && !complete) begin
                memwb_q <= '0;
                if (!busy) begin
                    state   <= S_BUSY;
                    counter <= CNT_W'(MEM_LATENCY - 1);
                end else begin
                    counter <= counter - CNT_W'(1);
                end
            end else begin
                memwb_q <= {mem_to_reg, alu_result, reg_write_eff, write_reg,
                            (complete && is_load) ? rd_data : 32'd0};
                state   <= S_IDLE;
                counter <= '0;
            end
        end
    end

    assign bus.MEMWBReg  = memwb_q;
    assign bus.addrError = addr_err_q;
    assign bus.memStall  = rst_n & stall;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: one instance at latency 1 and one at latency 3,
// each compared against a word-array reference model.
module tb_memory_stage;
    logic clk;
    logic rst_n;

    memory_stage_if if1 ();
    memory_stage_if if3 ();

    memory_stage #(.ADDR_W(8), .MEM_LATENCY(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    memory_stage #(.ADDR_W(8), .MEM_LATENCY(3)) u_lat3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] ref_mem [2][256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [74:0] got, input logic [74:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [74:0] pack(input logic rw, mw, m2r, mr, ovf, zr,
                                         input logic [4:0] wr, input logic [31:0] sd, alu);
        return {rw, mw, m2r, mr, ovf, zr, wr, sd, alu};
    endfunction

    task automatic drive(input bit sel, input logic [74:0] v);
        if (sel) if3.EXMEMReg = v;
        else     if1.EXMEMReg = v;
    endtask

    // Applies one op starting just after a rising edge and checks every cycle
    // it occupies the stage; returns just after its completing edge.
    task automatic do_op(input bit sel, input logic rw, mw, m2r, mr, ovf,
                         input logic [4:0] wr, input logic [31:0] sd, alu);
        int          lat, n;
        bit          req, mis, valid, store, load;
        int          idx;
        logic [31:0] res;
        logic [70:0] exp, got;
        lat   = sel ? 3 : 1;
        req   = mr || mw;
        mis   = req && (alu % 4 != 0);
        valid = req && !mis && !ovf;
        store = valid && mw;
        load  = valid && mr && !mw;
        idx   = (alu / 4) % 256;
        res   = load ? ref_mem[sel][idx] : 32'd0;
        exp   = {m2r, alu, rw && !ovf && !mis, wr, res};
        n     = valid ? lat : 1;
        drive(sel, pack(rw, mw, m2r, mr, ovf, 1'($urandom_range(1)), wr, sd, alu));
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk_val("mem_stall", sel ? if3.memStall : if1.memStall, 75'(k < n));
            @(posedge clk);
            #1;
            got = sel ? if3.MEMWBReg : if1.MEMWBReg;
            if (k < n) chk_val("bubble", got, '0);
            else       chk_val("memwb", got, exp);
            chk_val("addr_error", sel ? if3.addrError : if1.addrError, 75'(k == n && mis));
        end
        if (store) ref_mem[sel][idx] = sd;
        drive(sel, '0);
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        bit          s;
        rst_n = 1'b0;
        if1.EXMEMReg = '0;
        if3.EXMEMReg = pack(1, 0, 1, 1, 0, 0, 5'd3, 32'd0, 32'h20);
        #3;
        chk_val("rst_memwb1", if1.MEMWBReg, '0);
        chk_val("rst_memwb3", if3.MEMWBReg, '0);
        chk_val("rst_addr_err3", if3.addrError, '0);
        chk_val("rst_stall3", if3.memStall, '0);
        if3.EXMEMReg = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fill the first 32 words of both memories with known data
        for (int i = 0; i < 32; i++) begin
            do_op(0, 0, 1, 0, 0, 0, 5'd0, $urandom, 32'(i * 4));
            do_op(1, 0, 1, 0, 0, 0, 5'd0, $urandom, 32'(i * 4));
        end

        // latency 1: store then load, R-type pass-through, wrapped address
        do_op(0, 0, 1, 0, 0, 0, 5'd0, 32'd165, 32'h10);
        do_op(0, 1, 0, 1, 1, 0, 5'd17, 32'd0, 32'h10);
        do_op(0, 1, 0, 0, 0, 0, 5'd9, 32'd0, 32'hFFFF_FFF1);
        do_op(0, 1, 0, 1, 1, 0, 5'd4, 32'd0, 32'h0000_0410);

        // latency 3: multi-cycle load, misaligned, overflow-squashed store
        do_op(1, 0, 1, 0, 0, 0, 5'd0, 32'd42, 32'h20);
        do_op(1, 1, 0, 1, 1, 0, 5'd5, 32'd0, 32'h20);
        do_op(1, 1, 0, 1, 1, 0, 5'd6, 32'd0, 32'h13);
        do_op(1, 0, 1, 0, 0, 1, 5'd0, 32'd7, 32'h30);
        do_op(1, 1, 0, 1, 1, 0, 5'd7, 32'd0, 32'h30);

        // latency 3: reset while a store is in flight
        if3.EXMEMReg = pack(0, 1, 0, 0, 0, 0, 5'd0, 32'd99, 32'h40);
        @(posedge clk);
        #1;
        chk_val("busy_stall", if3.memStall, 75'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_val("midrst_memwb", if3.MEMWBReg, '0);
        chk_val("midrst_stall", if3.memStall, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        if3.EXMEMReg = '0;
        @(posedge clk);
        #1;
        do_op(1, 1, 0, 1, 1, 0, 5'd8, 32'd0, 32'h40);

        // randomized mix on both latencies
        for (int i = 0; i < 300; i++) begin
            s    = 1'($urandom_range(1));
            kind = $urandom_range(3);
            a    = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(31) * 4);
            if ($urandom_range(7) == 0) a[1:0] = 2'($urandom_range(3));
            do_op(s, 1'($urandom_range(1)), kind[1], 1'($urandom_range(1)), kind[0],
                  ($urandom_range(7) == 0), 5'($urandom), $urandom, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
